// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor: the counter
// encodings, the predictor states and the sequential fetch step.
`ifndef BRANCH_PREDICTOR_PKG_SV
`define BRANCH_PREDICTOR_PKG_SV

package branch_predictor_pkg;

    // 2-bit saturating counter encodings; bit 1 is the taken/not-taken decision
    localparam logic [1:0] BP_CNT_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] BP_CNT_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] BP_CNT_WT  = 2'b10;  // weak taken (fresh allocations)
    localparam logic [1:0] BP_CNT_ST  = 2'b11;  // strong taken

    // Predictor operating states
    typedef enum logic {
        BP_ST_INIT = 1'b0,  // sweeping valid bits to zero
        BP_ST_RUN  = 1'b1   // normal lookup/update operation
    } bp_state_e;

    // Sequential fetch distance used for the not-taken next PC
    localparam logic [63:0] BP_FETCH_STEP = 64'd4;

endpackage

`endif

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating branch counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Step toward strong taken / strong not-taken, holding at either end
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != BP_CNT_ST) begin
                cnt_next = cnt + 2'd1;
            end
        end else begin
            if (cnt != BP_CNT_SNT) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor with tagged targets and 2-bit
// saturating counters. One registered lookup and one update per cycle.
// After reset the valid bits are swept clear one entry per cycle before
// the table is used.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready_out,
    input  logic        lookup_valid_in,
    input  logic [63:0] lookup_pc_in,
    output logic        prediction_valid_out,
    output logic        predicted_taken_out,
    output logic [63:0] predicted_pc_out,
    input  logic        update_valid_in,
    input  logic [63:0] update_pc_in,
    input  logic        update_taken_in,
    input  logic [63:0] update_target_in,
    input  logic        update_mispredicted_in,
    output logic [31:0] mispredict_count_out
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [INDEX_BITS-1:0] INDEX_ONE  = INDEX_BITS'(1);

    // Table storage
    logic                valid_reg  [ENTRIES];
    logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
    logic [63:0]         target_reg [ENTRIES];
    logic [1:0]          cnt_reg    [ENTRIES];

    // Control
    bp_state_e             state_reg;
    bp_state_e             state_next;
    logic [INDEX_BITS-1:0] sweep_reg;
    logic                  sweep_en;
    logic                  table_en;

    // Registered outputs
    logic        pred_valid_reg;
    logic        pred_taken_reg;
    logic [63:0] pred_pc_reg;
    logic [31:0] mispredict_count_reg;

    // Address decode; PC bits [1:0] and bits above the tag never matter
    logic [INDEX_BITS-1:0] lk_index;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] up_index;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  unused_pc_bits;

    assign lk_index = lookup_pc_in[INDEX_BITS+1:2];
    assign lk_tag   = lookup_pc_in[TAG_HI:TAG_LO];
    assign up_index = update_pc_in[INDEX_BITS+1:2];
    assign up_tag   = update_pc_in[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{lookup_pc_in[1:0], lookup_pc_in[63:TAG_HI+1],
                              update_pc_in[1:0], update_pc_in[63:TAG_HI+1]};

    // Lookup: reads pre-update contents, so a same-cycle update is not bypassed
    logic lk_hit;
    logic lk_taken;

    assign lk_hit   = valid_reg[lk_index] && (tag_reg[lk_index] == lk_tag);
    assign lk_taken = table_en && lk_hit && cnt_reg[lk_index][1];

    // Update: hit detection and counter training
    logic       up_hit;
    logic [1:0] up_cnt;
    logic [1:0] up_cnt_next;

    assign up_hit = valid_reg[up_index] && (tag_reg[up_index] == up_tag);
    assign up_cnt = cnt_reg[up_index];

    bp_sat_counter u_sat_counter (
        .cnt      (up_cnt),
        .taken    (update_taken_in),
        .cnt_next (up_cnt_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BP_ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: leave INIT once the last entry has been cleared
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BP_ST_INIT: if (sweep_reg == LAST_INDEX) state_next = BP_ST_RUN;
            BP_ST_RUN:  state_next = BP_ST_RUN;
        endcase
    end

    // State outputs: sweep while initialising, use the table only when running
    always_comb begin
        ready_out = (state_reg == BP_ST_RUN);
        sweep_en  = (state_reg == BP_ST_INIT);
        table_en  = (state_reg == BP_ST_RUN);
    end

    // Sweep pointer walks every index once per initialisation
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_reg <= '0;
        end else if (sweep_en) begin
            sweep_reg <= sweep_reg + INDEX_ONE;
        end
    end

    // Table writes: sweep clears, then hits train and taken misses allocate
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_en) begin
                valid_reg[sweep_reg] <= 1'b0;
            end else if (table_en && update_valid_in) begin
                if (up_hit) begin
                    cnt_reg[up_index] <= up_cnt_next;
                    if (update_taken_in) begin
                        target_reg[up_index] <= update_target_in;
                    end
                end else if (update_taken_in) begin
                    valid_reg[up_index]  <= 1'b1;
                    tag_reg[up_index]    <= up_tag;
                    target_reg[up_index] <= update_target_in;
                    cnt_reg[up_index]    <= BP_CNT_WT;
                end
            end
        end
    end

    // Registered prediction; taken/pc hold when no lookup is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_pc_reg    <= '0;
        end else if (lookup_valid_in) begin
            pred_valid_reg <= 1'b1;
            pred_taken_reg <= lk_taken;
            pred_pc_reg    <= lk_taken ? target_reg[lk_index]
                                       : lookup_pc_in + BP_FETCH_STEP;
        end else begin
            pred_valid_reg <= 1'b0;
        end
    end

    // Saturating count of branch-unit mispredicts accepted while running
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count_reg <= '0;
        end else if (table_en && update_valid_in && update_mispredicted_in &&
                     (mispredict_count_reg != 32'hFFFF_FFFF)) begin
            mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign prediction_valid_out = pred_valid_reg;
    assign predicted_taken_out  = pred_taken_reg;
    assign predicted_pc_out     = pred_pc_reg;
    assign mispredict_count_out = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: hand vectors for the documented scenarios,
// then random traffic checked every cycle against a table model.
module tb_branch_predictor;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_out;
    logic        lookup_valid_in;
    logic [63:0] lookup_pc_in;
    logic        prediction_valid_out;
    logic        predicted_taken_out;
    logic [63:0] predicted_pc_out;
    logic        update_valid_in;
    logic [63:0] update_pc_in;
    logic        update_taken_in;
    logic [63:0] update_target_in;
    logic        update_mispredicted_in;
    logic [31:0] mispredict_count_out;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .TAG_BITS(10)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ready_out              (ready_out),
        .lookup_valid_in        (lookup_valid_in),
        .lookup_pc_in           (lookup_pc_in),
        .prediction_valid_out   (prediction_valid_out),
        .predicted_taken_out    (predicted_taken_out),
        .predicted_pc_out       (predicted_pc_out),
        .update_valid_in        (update_valid_in),
        .update_pc_in           (update_pc_in),
        .update_taken_in        (update_taken_in),
        .update_target_in       (update_target_in),
        .update_mispredicted_in (update_mispredicted_in),
        .mispredict_count_out   (mispredict_count_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one record per table slot, counter kept as 0..3
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [63:0] m_tgt   [N];
    int          m_cnt   [N];
    int          init_left = N;
    bit          e_pv, e_pt;
    logic [63:0] e_ppc;
    logic [31:0] e_cnt;

    typedef struct {
        bit          uv;
        logic [63:0] upc;
        bit          ut;
        logic [63:0] utgt;
        bit          um;
        logic [63:0] lpc;
        bit          exp_pt;
        logic [63:0] exp_ppc;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the spec's rules
    task automatic model_edge(input bit rst, input bit lv, input logic [63:0] lpc,
                              input bit uv, input logic [63:0] upc, input bit ut,
                              input logic [63:0] utgt, input bit um);
        int unsigned li, ui, lt, utg;
        bit in_init, tk;
        if (rst) begin
            init_left = N;
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
            e_pv = 1'b0; e_pt = 1'b0; e_ppc = '0; e_cnt = '0;
        end else begin
            in_init = (init_left > 0);
            if (lv) begin
                li = int'((lpc >> 2) % 64);
                lt = int'((lpc >> 8) % 1024);
                tk = !in_init && m_valid[li] && (m_tag[li] == lt) && (m_cnt[li] >= 2);
                e_pv  = 1'b1;
                e_pt  = tk;
                e_ppc = tk ? m_tgt[li] : lpc + 64'd4;
            end else begin
                e_pv = 1'b0;
            end
            if (!in_init && uv) begin
                ui  = int'((upc >> 2) % 64);
                utg = int'((upc >> 8) % 1024);
                if (m_valid[ui] && m_tag[ui] == utg) begin
                    if (ut) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
                    else    m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
                    if (ut) m_tgt[ui] = utgt;
                end else if (ut) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = utg;
                    m_tgt[ui]   = utgt;
                    m_cnt[ui]   = 2;
                end
                if (um && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
            end
            if (in_init) init_left--;
        end
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge, compare
    task automatic step(input bit rst, input bit lv, input logic [63:0] lpc,
                        input bit uv, input logic [63:0] upc, input bit ut,
                        input logic [63:0] utgt, input bit um);
        reset = rst; lookup_valid_in = lv; lookup_pc_in = lpc;
        update_valid_in = uv; update_pc_in = upc; update_taken_in = ut;
        update_target_in = utgt; update_mispredicted_in = um;
        model_edge(rst, lv, lpc, uv, upc, ut, utgt, um);
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0d lk=%0d lpc=%0h upd=%0d upc=%0h tk=%0d tgt=%0h mp=%0d -> rdy=%0d pv=%0d pt=%0d ppc=%0h cnt=%0h",
                 $time, rst, lv, lpc, uv, upc, ut, utgt, um,
                 ready_out, prediction_valid_out, predicted_taken_out, predicted_pc_out, mispredict_count_out);
        chk("ready", 64'(ready_out), 64'(init_left == 0));
        chk("pred_valid", 64'(prediction_valid_out), 64'(e_pv));
        chk("pred_taken", 64'(predicted_taken_out), 64'(e_pt));
        chk("pred_pc", predicted_pc_out, e_ppc);
        chk("mp_count", 64'(mispredict_count_out), 64'(e_cnt));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic lookup(input logic [63:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    function automatic vec_t mk(input bit uv, input logic [63:0] upc, input bit ut,
                                input logic [63:0] utgt, input bit um, input logic [63:0] lpc,
                                input bit ept, input logic [63:0] eppc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um;
        v.lpc = lpc; v.exp_pt = ept; v.exp_ppc = eppc;
        return v;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        int unsigned idx;
        p = 64'h0;
        idx = $urandom_range(0, 3);
        if (idx == 3) idx = 63;
        p[17:8] = 10'($urandom_range(0, 2));
        p[7:2]  = 6'(idx);
        p[1:0]  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
            p[63:32] = $urandom;
            p[31:18] = 14'($urandom);
        end
        return p;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand vectors, all issued after init with an empty table
        vt[0]  = mk(1, 64'h1000, 1, 64'h2000, 1, 64'h1000, 0, 64'h1004); // allocate, same-cycle lookup misses
        vt[1]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h1000, 1, 64'h2000); // hit, weak taken
        vt[2]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h1100, 0, 64'h1104); // same index, other tag
        vt[3]  = mk(1, 64'h1000, 1, 64'h2000, 1, 64'h1000, 1, 64'h2000); // -> strong taken
        vt[4]  = mk(1, 64'h1000, 1, 64'h2000, 0, 64'h1000, 1, 64'h2000);
        vt[5]  = mk(1, 64'h1000, 1, 64'h2000, 0, 64'h1000, 1, 64'h2000); // fourth taken, held at 11
        vt[6]  = mk(1, 64'h1000, 0, 64'h9999, 1, 64'h1000, 1, 64'h2000); // -> weak taken
        vt[7]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h1000, 1, 64'h2000); // still taken, target kept
        vt[8]  = mk(1, 64'h1000, 0, 64'h9999, 1, 64'h1000, 1, 64'h2000); // -> weak not-taken
        vt[9]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h1000, 0, 64'h1004);
        vt[10] = mk(1, 64'h1000, 0, 64'h9999, 0, 64'h1000, 0, 64'h1004); // -> strong not-taken
        vt[11] = mk(1, 64'h1000, 0, 64'h9999, 0, 64'h1000, 0, 64'h1004); // held at 00
        vt[12] = mk(1, 64'h1000, 0, 64'h9999, 0, 64'h1000, 0, 64'h1004);
        vt[13] = mk(1, 64'h1000, 1, 64'h2000, 1, 64'h1000, 0, 64'h1004); // -> weak not-taken
        vt[14] = mk(0, 64'h0,    0, 64'h0,    0, 64'h1000, 0, 64'h1004); // no underflow wrap
        vt[15] = mk(1, 64'h1000, 1, 64'h2400, 0, 64'h1000, 0, 64'h1004); // -> weak taken, new target
        vt[16] = mk(1, 64'h1000, 0, 64'h9999, 0, 64'h1000, 1, 64'h2400);
        vt[17] = mk(1, 64'h3000, 1, 64'h4000, 0, 64'h3000, 0, 64'h3004); // hazard: no bypass
        vt[18] = mk(0, 64'h0,    0, 64'h0,    0, 64'h3000, 1, 64'h4000);
        vt[19] = mk(0, 64'h0,    0, 64'h0,    0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0); // pc+4 wraps

        // Reset for two cycles
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("reset_ready", 64'(ready_out), 64'h0);
        chk("reset_pv", 64'(prediction_valid_out), 64'h0);
        chk("reset_ppc", predicted_pc_out, 64'h0);
        chk("reset_count", 64'(mispredict_count_out), 64'h0);

        // Init sweep: ready rises on exactly the 64th cycle; updates are ignored
        for (int k = 1; k <= 64; k++) begin
            if (k == 1) lookup(64'h1000);
            else if (k == 2) step(1'b0, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b1, 64'h7000, 1'b0);
            else idle();
            if (k == 1) begin
                chk("init_lookup_pv", 64'(prediction_valid_out), 64'h1);
                chk("init_lookup_pt", 64'(predicted_taken_out), 64'h0);
                chk("init_lookup_pc", predicted_pc_out, 64'h1004);
            end
            if (k == 63) chk("ready_before", 64'(ready_out), 64'h0);
            if (k == 64) chk("ready_after", 64'(ready_out), 64'h1);
        end

        // Table-driven scenarios
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utgt, vt[i].um);
            chk($sformatf("vec%0d_pt", i), 64'(predicted_taken_out), 64'(vt[i].exp_pt));
            chk($sformatf("vec%0d_pc", i), predicted_pc_out, vt[i].exp_ppc);
        end
        chk("mp_count_five", 64'(mispredict_count_out), 64'd5);

        // Outputs hold while no lookup is presented
        idle();
        chk("hold_pv", 64'(prediction_valid_out), 64'h0);
        chk("hold_pc", predicted_pc_out, 64'h0);

        // Statistic saturation
        force dut.mispredict_count_reg = 32'hFFFF_FFFF;
        #2;
        release dut.mispredict_count_reg;
        e_cnt = 32'hFFFF_FFFF;
        chk("mp_forced", 64'(mispredict_count_out), 64'hFFFF_FFFF);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5000, 1'b0, 64'h0, 1'b1);
        chk("mp_saturate", 64'(mispredict_count_out), 64'hFFFF_FFFF);

        // Reset mid-run clears the table and the statistic
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
        lookup(64'h1000);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
        lookup(64'h1000);
        chk("populated_pt", 64'(predicted_taken_out), 64'h1);
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("rerun_count", 64'(mispredict_count_out), 64'h0);
        for (int k = 0; k < 30; k++) idle();
        // Reset again mid-sweep: the sweep restarts from index 0
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            idle();
            if (k == 63) chk("resweep_before", 64'(ready_out), 64'h0);
            if (k == 64) chk("resweep_after", 64'(ready_out), 64'h1);
        end
        lookup(64'h1000);
        chk("after_reset_pt", 64'(predicted_taken_out), 64'h0);
        chk("after_reset_pc", predicted_pc_out, 64'h1004);
        chk("after_reset_count", 64'(mispredict_count_out), 64'h0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bit rst, lv, uv, ut, um;
            rst = ($urandom_range(0, 299) == 0);
            lv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 2) != 0);
            ut  = ($urandom_range(0, 1) == 1);
            um  = (init_left == 0) && ($urandom_range(0, 1) == 1);
            step(rst, lv, rand_pc(), uv, rand_pc(), ut, {$urandom, $urandom}, um);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side dynamic branch predictor: the producer of the `predicted_taken` bit and the consumer of the resolved outcome/mispredict result that the execute-stage branch unit computes. Holds a direct-mapped table of 2-bit saturating counters with tagged target entries. Answers one fetch lookup per cycle with a registered prediction. Absorbs one resolved-branch update per cycle from execute.

## Interface
- `INDEX_BITS`, default 6: log2 of table entries (64).
- `TAG_BITS`, default 10: tag width stored per entry.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `ready_out` out 1: table initialised; low during init sweep.
- `lookup_valid_in` in 1: fetch requests a prediction this cycle.
- `lookup_pc_in` in 64: fetch PC.
- `prediction_valid_out` out 1: registered; high the cycle after an accepted lookup.
- `predicted_taken_out` out 1: prediction bit for execute's branch unit.
- `predicted_pc_out` out 64: next fetch PC.
- `update_valid_in` in 1: execute resolved a branch/jump this cycle.
- `update_pc_in` in 64: PC of the resolved instruction.
- `update_taken_in` in 1: actual outcome.
- `update_target_in` in 64: actual taken target.
- `update_mispredicted_in` in 1: branch unit's mispredict result.
- `mispredict_count_out` out 32: saturating mispredict statistic.

## Operation
- **Index:** `pc[INDEX_BITS+1:2]`. **Tag:** `pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`. Bits [1:0] are ignored.
- **Entry contents:** valid (1), tag, target (64), counter (2).
- **Counter encoding:**
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- **Hit:** entry valid and tag equal.
- **Lookup result:**
  - Taken iff hit and `counter[1]` = 1.
  - `predicted_pc_out` = target if taken, else `lookup_pc_in + 4`. The add is modulo 2^64, so wrap-around from 0xFFFF_FFFF_FFFF_FFFC gives 0.
- **Update on hit:**
  - Counter increments if taken, decrements if not; saturates at 11 and 00.
  - Target is overwritten only when taken.
- **Update on miss, taken:** allocate the entry. Set valid=1, tag, target, counter=10, evicting any prior entry.
- **Update on miss, not-taken:** no table change.
- **Mispredict statistic:** `mispredict_count_out` increments when `update_valid_in & update_mispredicted_in`. It saturates at 0xFFFF_FFFF.
- **State machine:**
  - INIT: clears valid bits one entry per cycle, index 0 up to 2^INDEX_BITS-1. `ready_out`=0. Lookups return `prediction_valid_out`=1 with not-taken and pc+4. Updates are ignored.
  - INIT → RUN after the last index is cleared.
  - RUN: normal operation. RUN → INIT only on `reset`.

## Timing
- **Reset values:** state=INIT, sweep index=0, `ready_out`=0, `prediction_valid_out`=0, `predicted_taken_out`=0, `predicted_pc_out`=0, `mispredict_count_out`=0.
- **`ready_out`:** rises exactly 2^INDEX_BITS cycles after reset deasserts (64 at default).
- **Lookup latency:** 1 cycle. Outputs hold their last value while `lookup_valid_in`=0; `prediction_valid_out` drops to 0 in that case.
- **Update latency:** the table write is visible to a lookup issued the following cycle.
- **Same-cycle lookup and update to the same index:** the lookup sees pre-update contents. No bypass.
- **Reset mid-sweep or mid-RUN:** restarts INIT at index 0. All entries are re-cleared and the counter is zeroed.
- **Back-to-back updates to the same entry:** each is applied in order, one per cycle.

## Structure
- **Shared header:** counter encodings (`BP_CNT_SNT`/`WNT`/`WT`/`ST`), init/run state encodings, and the fetch step constant 4. Guarded like the existing branch header.
- **Sub-module `bp_sat_counter`:** combinational 2-bit saturating next-state from (counter, taken).
- **Storage:** the table is flop arrays in `branch_predictor`; no SRAM macro.

## Test plan
- **Reset/init:** assert reset 2 cycles, release → `ready_out`=0 for 64 cycles, then 1. A lookup at pc 0x1000 during INIT → not-taken, `predicted_pc_out`=0x1004.
- **Allocate then hit:** update pc 0x1000 taken target 0x2000 → next-cycle lookup 0x1000 returns taken, 0x2000. Lookup 0x1100 (same index, different tag) → not-taken, 0x1104.
- **Saturation:**
  - Four taken updates at 0x1000 → counter 11.
  - Then one not-taken → still predicts taken (10).
  - A second not-taken → not-taken (01).
  - Three more not-taken → counter 00, no underflow.
- **Same-cycle hazard:** update 0x3000 taken (target 0x4000) and lookup 0x3000 in the same cycle → lookup returns not-taken, 0x3004. Repeat the lookup next cycle → taken, 0x4000.
- **Statistic and wrap:**
  - Five updates with mispredicted=1 → count 5.
  - Force the count to 0xFFFF_FFFF and mispredict again → stays 0xFFFF_FFFF.
  - Lookup pc 0xFFFF_FFFF_FFFF_FFFC with no entry → `predicted_pc_out` 0.
- **Reset mid-operation:** populate 0x1000, assert reset in RUN → after re-init, lookup 0x1000 returns not-taken. `mispredict_count_out`=0.
